// File: rtl/frame_buffer_flip_system.sv
// Double-buffered frame store: CPU owns the back bank, pixel port reads the front bank, flips land on vsync.
// Optional macro FRAME_COPY_ON_FLIP_EN: every applied flip copies the new front bank into the new back bank.
//
// state | meaning
// IDLE  | CPU owns back-bank port A; flips and fill requests are accepted
// FILL  | engine writes fill_value to back[cnt], one word per cycle
// COPY  | engine reads front[cnt] on port A, writes back[cnt-1] (macro builds only)
module frame_buffer_flip_system #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8192
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_chipselect,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_waitrequest,
    input  logic [ADDR_W-1:0] pix_address,
    input  logic              pix_read,
    output logic [DATA_W-1:0] pix_readdata,
    input  logic              vsync_pulse,
    input  logic              flip_req,
    output logic              flip_pending,
    output logic              front_sel,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, COPY = 2'd2} state_t;

    logic [DATA_W-1:0] bank0 [DEPTH];
    logic [DATA_W-1:0] bank1 [DEPTH];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] fill_val_q, fill_val_d;
    logic              front_sel_q, front_sel_d;
    logic              flip_pending_q, flip_pending_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] cpu_readdata_q, cpu_readdata_d;
    logic [DATA_W-1:0] pix_readdata_q, pix_readdata_d;

    logic              we;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_data;
    logic              cpu_in_range, pix_in_range;
    logic [IDX_W-1:0]  cpu_idx, pix_idx;
    logic [DATA_W-1:0] cpu_back_word, pix_front_word;

    assign cpu_in_range   = {1'b0, cpu_address} < DEPTH_C;
    assign pix_in_range   = {1'b0, pix_address} < DEPTH_C;
    assign cpu_idx        = cpu_address[IDX_W-1:0];
    assign pix_idx        = pix_address[IDX_W-1:0];
    assign cpu_back_word  = front_sel_q ? bank0[cpu_idx] : bank1[cpu_idx];
    assign pix_front_word = front_sel_q ? bank1[pix_idx] : bank0[pix_idx];

`ifdef FRAME_COPY_ON_FLIP_EN
    logic [DATA_W-1:0] copy_rd_q, copy_rd_d;
    logic [IDX_W-1:0]  eng_idx;
    logic [CNT_W-1:0]  cnt_m1;
    logic [DATA_W-1:0] eng_front_word;

    assign eng_idx        = cnt_q[IDX_W-1:0];
    assign cnt_m1         = cnt_q - CNT_W'(1);
    assign eng_front_word = front_sel_q ? bank1[eng_idx] : bank0[eng_idx];
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        fill_val_d     = fill_val_q;
        front_sel_d    = front_sel_q;
        flip_pending_d = flip_pending_q | flip_req;
        cpu_readdata_d = cpu_readdata_q;
        pix_readdata_d = pix_readdata_q;
        we             = 1'b0;
        w_idx          = cpu_idx;
        w_data         = cpu_writedata;
`ifdef FRAME_COPY_ON_FLIP_EN
        copy_rd_d      = copy_rd_q;
`endif
        if (pix_read) begin
            pix_readdata_d = pix_in_range ? pix_front_word : '0;
        end
        case (state_q)
            IDLE: begin
                if (cpu_chipselect && cpu_write) begin
                    we = cpu_in_range;
                end else if (cpu_chipselect) begin
                    cpu_readdata_d = cpu_in_range ? cpu_back_word : '0;
                end
                // a flip on this edge takes priority over a fill request
                if (vsync_pulse && flip_pending_q) begin
                    front_sel_d    = ~front_sel_q;
                    flip_pending_d = 1'b0;
`ifdef FRAME_COPY_ON_FLIP_EN
                    state_d        = COPY;
                    cnt_d          = '0;
`endif
                end else if (fill_start) begin
                    state_d    = FILL;
                    cnt_d      = '0;
                    fill_val_d = fill_value;
                end
            end
            FILL: begin
                we     = 1'b1;
                w_idx  = cnt_q[IDX_W-1:0];
                w_data = fill_val_q;
                if (cnt_q == LAST_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef FRAME_COPY_ON_FLIP_EN
            COPY: begin
                // read front[cnt] now, write it to back[cnt-1] one cycle later
                copy_rd_d = eng_front_word;
                if (cnt_q != '0) begin
                    we     = 1'b1;
                    w_idx  = cnt_m1[IDX_W-1:0];
                    w_data = copy_rd_q;
                end
                if (cnt_q == DEPTH_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            fill_val_q     <= '0;
            front_sel_q    <= 1'b0;
            flip_pending_q <= 1'b0;
            busy_q         <= 1'b0;
            cpu_readdata_q <= '0;
            pix_readdata_q <= '0;
`ifdef FRAME_COPY_ON_FLIP_EN
            copy_rd_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fill_val_q     <= fill_val_d;
            front_sel_q    <= front_sel_d;
            flip_pending_q <= flip_pending_d;
            busy_q         <= busy_d;
            cpu_readdata_q <= cpu_readdata_d;
            pix_readdata_q <= pix_readdata_d;
`ifdef FRAME_COPY_ON_FLIP_EN
            copy_rd_q      <= copy_rd_d;
`endif
        end
    end

    // RAM contents survive reset; only the back bank is ever written
    always_ff @(posedge clk_clk) begin
        if (we) begin
            if (front_sel_q) begin
                bank0[w_idx] <= w_data;
            end else begin
                bank1[w_idx] <= w_data;
            end
        end
    end

    assign cpu_readdata    = cpu_readdata_q;
    assign pix_readdata    = pix_readdata_q;
    assign cpu_waitrequest = busy_q;
    assign busy            = busy_q;
    assign front_sel       = front_sel_q;
    assign flip_pending    = flip_pending_q;

endmodule

// File: tb/tb_frame_buffer_flip_system.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural frame-store model.
module tb_frame_buffer_flip_system;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] cpu_address = '0;
    logic              cpu_chipselect = 1'b0;
    logic              cpu_write = 1'b0;
    logic [DATA_W-1:0] cpu_writedata = '0;
    logic [DATA_W-1:0] cpu_readdata;
    logic              cpu_waitrequest;
    logic [ADDR_W-1:0] pix_address = '0;
    logic              pix_read = 1'b0;
    logic [DATA_W-1:0] pix_readdata;
    logic              vsync_pulse = 1'b0;
    logic              flip_req = 1'b0;
    logic              flip_pending;
    logic              front_sel;
    logic              fill_start = 1'b0;
    logic [DATA_W-1:0] fill_value = '0;
    logic              busy;

    always #5 clk = ~clk;

    frame_buffer_flip_system #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .cpu_address(cpu_address), .cpu_chipselect(cpu_chipselect), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
        .pix_address(pix_address), .pix_read(pix_read), .pix_readdata(pix_readdata),
        .vsync_pulse(vsync_pulse), .flip_req(flip_req), .flip_pending(flip_pending),
        .front_sel(front_sel), .fill_start(fill_start), .fill_value(fill_value), .busy(busy)
    );

    int n_chk = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // behavioural model: two word arrays, a front index, a pending flag and an engine job
    logic [DATA_W-1:0] m_mem [2][DEPTH];
    int                m_front = 0;
    bit                m_pend = 0;
    bit                m_busy = 0;
    bit                m_copy = 0;
    int                m_k = 0;
    logic [DATA_W-1:0] m_fv = '0;
    logic [DATA_W-1:0] exp_cpu = '0;
    logic [DATA_W-1:0] exp_pix = '0;
    bit                mb;
    int                ca, pa, fb, bb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_front = 0; m_pend = 0; m_busy = 0; m_copy = 0; m_k = 0;
            exp_cpu = '0; exp_pix = '0;
        end else begin
            mb = m_busy;
            fb = m_front;
            bb = 1 - m_front;
            ca = int'(cpu_address);
            pa = int'(pix_address);
            if (pix_read) exp_pix = (pa < DEPTH) ? m_mem[fb][pa] : '0;
            if (!mb && cpu_chipselect) begin
                if (cpu_write) begin
                    if (ca < DEPTH) m_mem[bb][ca] = cpu_writedata;
                end else begin
                    exp_cpu = (ca < DEPTH) ? m_mem[bb][ca] : '0;
                end
            end
            if (mb) begin
                m_k++;
                if (!m_copy) begin
                    m_mem[bb][m_k-1] = m_fv;
                    if (m_k == DEPTH) m_busy = 0;
                end else if (m_k == DEPTH + 1) begin
                    for (int i = 0; i < DEPTH; i++) m_mem[bb][i] = m_mem[fb][i];
                    m_busy = 0;
                end
            end
            if (!mb && vsync_pulse && m_pend) begin
                m_front = 1 - m_front;
                m_pend = 0;
`ifdef FRAME_COPY_ON_FLIP_EN
                m_busy = 1; m_copy = 1; m_k = 0;
`endif
            end else begin
                if (flip_req) m_pend = 1;
                if (!mb && fill_start) begin
                    m_busy = 1; m_copy = 0; m_k = 0; m_fv = fill_value;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("front_sel", front_sel, m_front);
            chk("flip_pending", flip_pending, m_pend);
            chk("busy", busy, m_busy);
            chk("cpu_waitrequest", cpu_waitrequest, m_busy);
            chk("cpu_readdata", cpu_readdata, exp_cpu);
            chk("pix_readdata", pix_readdata, exp_pix);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        cpu_chipselect = 0; cpu_write = 0; pix_read = 0;
        vsync_pulse = 0; flip_req = 0; fill_start = 0;
    endtask

    task automatic cpu_wr(input int a, input int d);
        cpu_chipselect = 1; cpu_write = 1; cpu_address = ADDR_W'(a); cpu_writedata = DATA_W'(d);
        tick(); clear_strobes();
    endtask

    task automatic cpu_rd(input int a);
        cpu_chipselect = 1; cpu_write = 0; cpu_address = ADDR_W'(a);
        tick(); clear_strobes();
    endtask

    task automatic pix_rd(input int a);
        pix_read = 1; pix_address = ADDR_W'(a);
        tick(); clear_strobes();
    endtask

    task automatic pulse_flip();
        flip_req = 1; tick(); clear_strobes();
    endtask

    task automatic pulse_vsync();
        vsync_pulse = 1; tick(); clear_strobes();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin tick(); n++; end
        chk("wait_idle_timeout", busy, 0);
    endtask

    // poke: drive a CPU write while the engine is busy; it must be dropped
    task automatic do_fill(input int v, input bit poke, output int n);
        fill_start = 1; fill_value = DATA_W'(v);
        tick(); clear_strobes();
        n = 0;
        while (busy && n < 60) begin
            if (poke && n == 3) begin
                cpu_chipselect = 1; cpu_write = 1; cpu_address = 5'd3; cpu_writedata = 8'hEE;
            end else begin
                cpu_chipselect = 0; cpu_write = 0;
            end
            n++;
            tick();
        end
        clear_strobes();
    endtask

    initial begin
        int n;
        clear_strobes();
        rst_n = 0;
        tick();
        cmp_en = 1;
        tick();
        chk("rst_front_sel", front_sel, 0);
        chk("rst_flip_pending", flip_pending, 0);
        chk("rst_busy", busy, 0);
        chk("rst_waitrequest", cpu_waitrequest, 0);
        chk("rst_cpu_readdata", cpu_readdata, 0);
        chk("rst_pix_readdata", pix_readdata, 0);
        rst_n = 1;
        tick();

        do_fill(8'h11, 0, n);
        chk("fill1_busy_cycles", n, DEPTH);

        pulse_flip();
        repeat (100) tick();
        chk("pending_before_vsync", flip_pending, 1);
        chk("front_before_vsync", front_sel, 0);
        pulse_vsync();
        chk("front_after_vsync", front_sel, 1);
        chk("pending_after_vsync", flip_pending, 0);
        wait_idle();

        do_fill(8'h3C, 1, n);
        chk("fill2_busy_cycles", n, DEPTH);
        cpu_rd(3);
        chk("write_during_busy_dropped", cpu_readdata, 8'h3C);
        cpu_wr(5, 8'hA5);
        cpu_rd(5);
        chk("cpu_read_a5", cpu_readdata, 8'hA5);
        pix_rd(5);
        chk("pix_reads_front", pix_readdata, 8'h11);
        cpu_wr(16, 8'h55);
        cpu_rd(16);
        chk("out_of_range_read", cpu_readdata, 0);

        flip_req = 1; vsync_pulse = 1; tick(); clear_strobes();
        chk("same_cycle_no_flip", front_sel, 1);
        chk("same_cycle_pending", flip_pending, 1);
        repeat (5) tick();
        pulse_vsync();
        chk("later_vsync_flip", front_sel, 0);
        wait_idle();
        pix_rd(5);
        chk("pix_after_flip", pix_readdata, 8'hA5);

        pulse_flip();
        fill_start = 1; fill_value = 8'h42; vsync_pulse = 1; tick(); clear_strobes();
        chk("flip_wins_front", front_sel, 1);
`ifdef FRAME_COPY_ON_FLIP_EN
        chk("flip_wins_busy", busy, 1);
`else
        chk("flip_wins_busy", busy, 0);
`endif
        wait_idle();

        fill_start = 1; fill_value = 8'h77; tick(); clear_strobes();
        pulse_flip();
        pulse_vsync();
        chk("deferred_front", front_sel, 1);
        chk("deferred_pending", flip_pending, 1);
        wait_idle();
        pulse_vsync();
        chk("deferred_applied", front_sel, 0);
        chk("deferred_cleared", flip_pending, 0);
`ifdef FRAME_COPY_ON_FLIP_EN
        n = 0;
        while (busy && n < 60) begin n++; tick(); end
        chk("copy_busy_cycles", n, DEPTH + 1);
        for (int i = 0; i < DEPTH; i++) cpu_rd(i);
`else
        wait_idle();
`endif

        fill_start = 1; fill_value = 8'h99; tick(); clear_strobes();
        repeat (5) tick();
        rst_n = 0;
        tick();
        chk("midfill_rst_busy", busy, 0);
        chk("midfill_rst_front", front_sel, 0);
        chk("midfill_rst_cpu_rd", cpu_readdata, 0);
        chk("midfill_rst_pix_rd", pix_readdata, 0);
        rst_n = 1;
        tick();
        cpu_rd(0);
        chk("partial_fill_word0", cpu_readdata, 8'h99);
        cpu_rd(4);
        chk("partial_fill_word4", cpu_readdata, 8'h99);
        for (int i = 0; i < DEPTH; i++) begin cpu_rd(i); pix_rd(i); end

        for (int c = 0; c < 3000; c++) begin
            cpu_chipselect = ($urandom_range(0, 9) < 3);
            cpu_write      = $urandom_range(0, 1);
            cpu_address    = ADDR_W'($urandom_range(0, 31));
            cpu_writedata  = DATA_W'($urandom);
            pix_read       = $urandom_range(0, 1);
            pix_address    = ADDR_W'($urandom_range(0, 31));
            vsync_pulse    = ($urandom_range(0, 99) < 3);
            flip_req       = ($urandom_range(0, 99) < 3);
            fill_start     = ($urandom_range(0, 99) < 2);
            fill_value     = DATA_W'($urandom);
            tick();
        end
        clear_strobes();
        repeat (40) tick();
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
